// File: rtl/opsum_drain_ctrl.sv
// opsum_drain_ctrl: gates PE-array opsum pushes into NUM_CH parallel opsum FIFOs
// and drains them round-robin into GLB through a single arbiter req/grant port.
// Each 16-bit opsum becomes a halfword write. Every channel keeps its own
// address pointer. The push count is exact: no extra push on PUSH->DRAIN.
//
// Optional feature macro: OPSUM_WORD_PACK_EN. When defined, two halfwords on a
// channel are packed into one 32-bit word write, with a single-half flush when
// the FIFO runs dry.
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   start_i, clear_i    tile start (latches push_num_i/glb_base_addr_i), abort to IDLE
//   push_num_i          pushes required per enabled channel
//   glb_base_addr_i     GLB byte base address
//   ch_mask_i           per-channel enable
//   pe_array_move_i     PE array shifts out an opsum this cycle
//   fifo_empty_i/full_i per-FIFO status
//   fifo_pop_data_i     FIFO heads, channel c at [c*16 +: 16]
//   glb_busy_i          suppresses new requests
//   permit_i            arbiter grant
//   write_req_o         arbiter request
//   fifo_push_o/pop_o   per-FIFO push / one-hot pop
//   glb_write_*_o       GLB write address, byte enables, data
//   push_state_o        state == PUSH
//   done_o              state is IDLE or DONE
module opsum_drain_ctrl #(
  parameter int unsigned NUM_CH     = 4,
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned CNT_W      = 32,
  parameter logic [31:0] CH_STRIDE  = 32'h400,
  parameter int unsigned MAX_GRANTS = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start_i,
  input  logic                     clear_i,
  input  logic [CNT_W-1:0]         push_num_i,
  input  logic [31:0]              glb_base_addr_i,
  input  logic [NUM_CH-1:0]        ch_mask_i,
  input  logic                     pe_array_move_i,
  input  logic [NUM_CH-1:0]        fifo_empty_i,
  input  logic [NUM_CH-1:0]        fifo_full_i,
  input  logic [NUM_CH*DATA_W-1:0] fifo_pop_data_i,
  input  logic                     glb_busy_i,
  input  logic                     permit_i,
  output logic                     write_req_o,
  output logic [NUM_CH-1:0]        fifo_push_o,
  output logic [NUM_CH-1:0]        fifo_pop_o,
  output logic [31:0]              glb_write_addr_o,
  output logic [3:0]               glb_write_web_o,
  output logic [31:0]              glb_write_data_o,
  output logic                     push_state_o,
  output logic                     done_o
);
  localparam int unsigned CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int unsigned GC_W  = $clog2(MAX_GRANTS + 1);
  localparam int unsigned PTR_W = 16;

  typedef enum logic [1:0] {IDLE, PUSH, DRAIN, DONE} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   push_cnt_q, push_num_q;
  logic [31:0]        base_q;
  logic [PTR_W-1:0]   ptr_q [NUM_CH];
  logic [CH_W-1:0]    rr_ptr_q;
  logic [GC_W-1:0]    grant_cnt_q;

  logic               any_full, all_empty, drain_idle, push_done, push_go;
  logic [NUM_CH-1:0]  cand;
  logic [CH_W-1:0]    sel, scan_idx;
  logic [CH_W:0]      scan_sum;
  logic               sel_valid, fire;
  logic [DATA_W-1:0]  sel_data;
  logic [PTR_W-1:0]   sel_ptr;
  logic [31:0]        sel_addr;

  // Disabled channels never contribute to full/empty decisions.
  assign any_full  = |(fifo_full_i & ch_mask_i);
  assign all_empty = &(fifo_empty_i | ~ch_mask_i);
  assign push_done = (push_cnt_q == push_num_q);
  // push_cnt advances on move cycles even when no channel is enabled.
  assign push_go   = (state_q == PUSH) && pe_array_move_i && !any_full &&
                     (push_cnt_q < push_num_q) && !clear_i;

`ifdef OPSUM_WORD_PACK_EN
  logic [DATA_W-1:0]  hold_q [NUM_CH];
  logic [NUM_CH-1:0]  hold_v_q;
  // A held half on an empty FIFO is a drain candidate (flush). Flushing on any
  // empty FIFO in DRAIN keeps the DRAIN->PUSH return from stalling on a half word.
  assign cand       = ch_mask_i & (~fifo_empty_i | hold_v_q);
  assign drain_idle = all_empty && ((hold_v_q & ch_mask_i) == '0);
`else
  assign cand       = ch_mask_i & ~fifo_empty_i;
  assign drain_idle = all_empty;
`endif

  // Round-robin select: first candidate at or after rr_ptr, cyclic.
  always_comb begin
    sel       = '0;
    sel_valid = 1'b0;
    scan_sum  = '0;
    scan_idx  = '0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      scan_sum = {1'b0, rr_ptr_q} + (CH_W+1)'(k);
      if (scan_sum >= (CH_W+1)'(NUM_CH)) scan_sum = scan_sum - (CH_W+1)'(NUM_CH);
      scan_idx = scan_sum[CH_W-1:0];
      if (!sel_valid && cand[scan_idx]) begin
        sel       = scan_idx;
        sel_valid = 1'b1;
      end
    end
  end

  // Head data and pointer of the selected channel.
  always_comb begin
    sel_data = '0;
    sel_ptr  = '0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      if (sel == CH_W'(c)) begin
        sel_data = fifo_pop_data_i[c*DATA_W +: DATA_W];
        sel_ptr  = ptr_q[c];
      end
    end
  end

  assign sel_addr     = base_q + (32'(sel) * CH_STRIDE) + 32'(sel_ptr);
  assign write_req_o  = (state_q == DRAIN) && sel_valid && !glb_busy_i &&
                        (grant_cnt_q < GC_W'(MAX_GRANTS)) && !clear_i;
  assign fire         = write_req_o && permit_i;
  assign fifo_push_o  = {NUM_CH{push_go}} & ch_mask_i;
  assign push_state_o = (state_q == PUSH);
  assign done_o       = (state_q == IDLE) || (state_q == DONE);

  // GLB write lane formation and pop strobe.
  always_comb begin
    fifo_pop_o       = '0;
    glb_write_addr_o = sel_addr;
    glb_write_data_o = '0;
    glb_write_web_o  = '0;
`ifdef OPSUM_WORD_PACK_EN
    if (sel_valid) begin
      if (fifo_empty_i[sel]) begin
        glb_write_addr_o = {sel_addr[31:2], 2'b00};
        glb_write_data_o = {16'h0, hold_q[sel]};
        glb_write_web_o  = 4'b0011;
      end else if (!sel_addr[1]) begin
        glb_write_data_o = {16'h0, sel_data};
        glb_write_web_o  = 4'b0000;
      end else if (hold_v_q[sel]) begin
        glb_write_addr_o = {sel_addr[31:2], 2'b00};
        glb_write_data_o = {sel_data, hold_q[sel]};
        glb_write_web_o  = 4'b1111;
      end else begin
        glb_write_data_o = {sel_data, 16'h0};
        glb_write_web_o  = 4'b1100;
      end
    end
    if (fire && !fifo_empty_i[sel]) fifo_pop_o[sel] = 1'b1;
`else
    if (sel_valid) begin
      if (!sel_addr[1]) begin
        glb_write_data_o = {16'h0, sel_data};
        glb_write_web_o  = 4'b0011;
      end else begin
        glb_write_data_o = {sel_data, 16'h0};
        glb_write_web_o  = 4'b1100;
      end
    end
    if (fire) fifo_pop_o[sel] = 1'b1;
`endif
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; clear_i overrides everything.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_i) state_d = (push_num_i == '0) ? DONE : PUSH;
      PUSH:    if (any_full || push_done) state_d = DRAIN;
      DRAIN:   if (drain_idle) state_d = push_done ? DONE : PUSH;
      DONE:    state_d = DONE;
      default: state_d = IDLE;
    endcase
    if (clear_i) state_d = IDLE;
  end

  // Counters, pointers and latched tile parameters.
  always_ff @(posedge clk) begin
    if (!rst_n || clear_i) begin
      push_cnt_q  <= '0;
      push_num_q  <= '0;
      base_q      <= '0;
      rr_ptr_q    <= '0;
      grant_cnt_q <= '0;
      for (int unsigned c = 0; c < NUM_CH; c++) ptr_q[c] <= '0;
    end else begin
      if ((state_q == IDLE) && start_i) begin
        push_num_q <= push_num_i;
        base_q     <= glb_base_addr_i;
      end
      if (push_go) push_cnt_q <= push_cnt_q + CNT_W'(1);
      // A capped burst drops req for exactly one cycle, then the count restarts.
      if ((state_q != DRAIN) && (state_d == DRAIN))    grant_cnt_q <= '0;
      else if (fire)                                   grant_cnt_q <= grant_cnt_q + GC_W'(1);
      else if (grant_cnt_q == GC_W'(MAX_GRANTS))       grant_cnt_q <= '0;
      if (fire) begin
        ptr_q[sel] <= ptr_q[sel] + PTR_W'(2);
        rr_ptr_q   <= (sel == CH_W'(NUM_CH - 1)) ? '0 : sel + CH_W'(1);
      end
    end
  end

`ifdef OPSUM_WORD_PACK_EN
  // Low-half hold registers for word packing.
  always_ff @(posedge clk) begin
    if (!rst_n || clear_i) begin
      hold_v_q <= '0;
      for (int unsigned c = 0; c < NUM_CH; c++) hold_q[c] <= '0;
    end else if (fire) begin
      if (fifo_empty_i[sel] || sel_addr[1]) begin
        hold_v_q[sel] <= 1'b0;
      end else begin
        hold_v_q[sel] <= 1'b1;
        hold_q[sel]   <= sel_data;
      end
    end
  end
`endif

endmodule

// File: tb/tb_opsum_drain_ctrl.sv
// Directed bench for opsum_drain_ctrl (default build, NUM_CH=4). A small FIFO
// model responds to push/pop strobes; every GLB write is logged for checking.
// Channel c's n-th pushed opsum is 16'hA000 + c*16'h100 + n.
module tb_opsum_drain_ctrl;
  localparam int NCH = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n, start_i, clear_i, pe_array_move_i, glb_busy_i, permit_i;
  logic [31:0]       push_num_i, glb_base_addr_i;
  logic [NCH-1:0]    ch_mask_i, fifo_empty_i, fifo_full_i;
  logic [NCH*16-1:0] fifo_pop_data_i;
  logic              write_req_o, push_state_o, done_o;
  logic [NCH-1:0]    fifo_push_o, fifo_pop_o;
  logic [31:0]       glb_write_addr_o, glb_write_data_o;
  logic [3:0]        glb_write_web_o;

  opsum_drain_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .clear_i(clear_i),
    .push_num_i(push_num_i), .glb_base_addr_i(glb_base_addr_i), .ch_mask_i(ch_mask_i),
    .pe_array_move_i(pe_array_move_i), .fifo_empty_i(fifo_empty_i), .fifo_full_i(fifo_full_i),
    .fifo_pop_data_i(fifo_pop_data_i), .glb_busy_i(glb_busy_i), .permit_i(permit_i),
    .write_req_o(write_req_o), .fifo_push_o(fifo_push_o), .fifo_pop_o(fifo_pop_o),
    .glb_write_addr_o(glb_write_addr_o), .glb_write_web_o(glb_write_web_o),
    .glb_write_data_o(glb_write_data_o), .push_state_o(push_state_o), .done_o(done_o)
  );

  // FIFO model and write log.
  int          depth;
  logic        fifo_flush;
  int          cnt [NCH];
  logic [3:0]  head [NCH];
  logic [15:0] mem [NCH][16];
  int          push_total [NCH];
  int          cyc = 0;
  int          n_wr;
  logic [31:0] wr_addr [64];
  logic [31:0] wr_data [64];
  logic [3:0]  wr_web [64];
  logic [3:0]  wr_pop [64];
  int          wr_cyc [64];

  always_comb begin
    fifo_empty_i    = '0;
    fifo_full_i     = '0;
    fifo_pop_data_i = '0;
    for (int c = 0; c < NCH; c++) begin
      fifo_empty_i[c] = (cnt[c] == 0);
      fifo_full_i[c]  = (cnt[c] >= depth);
      fifo_pop_data_i[c*16 +: 16] = mem[c][head[c]];
    end
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (fifo_flush) begin
      for (int c = 0; c < NCH; c++) begin
        cnt[c]        <= 0;
        head[c]       <= '0;
        push_total[c] <= 0;
      end
      n_wr <= 0;
    end else begin
      for (int c = 0; c < NCH; c++) begin
        if (fifo_push_o[c]) begin
          mem[c][head[c] + 4'(cnt[c])] <= 16'hA000 + 16'(c * 256) + 16'(push_total[c]);
          push_total[c] <= push_total[c] + 1;
        end
        if (fifo_pop_o[c]) head[c] <= head[c] + 4'd1;
        cnt[c] <= cnt[c] + (fifo_push_o[c] ? 1 : 0) - (fifo_pop_o[c] ? 1 : 0);
      end
      if (write_req_o && permit_i && n_wr < 64) begin
        wr_addr[n_wr] <= glb_write_addr_o;
        wr_data[n_wr] <= glb_write_data_o;
        wr_web[n_wr]  <= glb_write_web_o;
        wr_pop[n_wr]  <= fifo_pop_o;
        wr_cyc[n_wr]  <= cyc;
        n_wr          <= n_wr + 1;
      end
    end
  end

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic do_clear();
    pe_array_move_i = 1'b0;
    permit_i        = 1'b0;
    glb_busy_i      = 1'b0;
    clear_i         = 1'b1;
    fifo_flush      = 1'b1;
    nxt();
    clear_i    = 1'b0;
    fifo_flush = 1'b0;
  endtask

  task automatic start_tile(input logic [31:0] num, input logic [31:0] base, input logic [3:0] mask);
    push_num_i      = num;
    glb_base_addr_i = base;
    ch_mask_i       = mask;
    start_i         = 1'b1;
    nxt();
    start_i = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (done_o !== 1'b1 && n < 200) begin nxt(); n++; end
    chk(tag, {31'd0, done_o}, 32'd1);
  endtask

  task automatic wait_req(input string tag);
    int n;
    n = 0;
    while (write_req_o !== 1'b1 && n < 200) begin nxt(); n++; end
    chk(tag, {31'd0, write_req_o}, 32'd1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_push"},  32'(fifo_push_o), 32'd0);
    chk({tag, "_pop"},   32'(fifo_pop_o), 32'd0);
    chk({tag, "_req"},   {31'd0, write_req_o}, 32'd0);
    chk({tag, "_pstate"}, {31'd0, push_state_o}, 32'd0);
    chk({tag, "_done"},  {31'd0, done_o}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; start_i = 1'b0; clear_i = 1'b0; push_num_i = '0; glb_base_addr_i = '0;
    ch_mask_i = '0; pe_array_move_i = 1'b0; glb_busy_i = 1'b0; permit_i = 1'b0;
    depth = 8; fifo_flush = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_outputs("reset");
    nxt();
    rst_n = 1'b1;
    fifo_flush = 1'b0;

    // Single channel, three halfword writes.
    do_clear();
    permit_i = 1'b1; pe_array_move_i = 1'b1;
    start_tile(32'd3, 32'h100, 4'b0001);
    chk("t1_pstate", {31'd0, push_state_o}, 32'd1);
    chk("t1_push0", 32'(fifo_push_o), 32'h1);
    wait_done("t1_done");
    chk("t1_npush0", 32'(push_total[0]), 32'd3);
    chk("t1_npush1", 32'(push_total[1]), 32'd0);
    chk("t1_nwr", 32'(n_wr), 32'd3);
    chk("t1_addr0", wr_addr[0], 32'h100);
    chk("t1_web0", 32'(wr_web[0]), 32'h3);
    chk("t1_data0", wr_data[0], 32'h0000A000);
    chk("t1_addr1", wr_addr[1], 32'h102);
    chk("t1_web1", 32'(wr_web[1]), 32'hC);
    chk("t1_data1", wr_data[1], 32'hA0010000);
    chk("t1_addr2", wr_addr[2], 32'h104);
    chk("t1_web2", 32'(wr_web[2]), 32'h3);
    chk("t1_data2", wr_data[2], 32'h0000A002);
    chk("t1_req_done", {31'd0, write_req_o}, 32'd0);

    // FIFO fills mid-tile: depth 2, five pushes total.
    do_clear();
    depth = 2; permit_i = 1'b1; pe_array_move_i = 1'b1;
    start_tile(32'd5, 32'h2000, 4'b0001);
    wait_done("t2_done");
    chk("t2_npush", 32'(push_total[0]), 32'd5);
    chk("t2_nwr", 32'(n_wr), 32'd5);
    chk("t2_addr1", wr_addr[1], 32'h2002);
    chk("t2_data1", wr_data[1], 32'hA0010000);
    chk("t2_addr4", wr_addr[4], 32'h2008);
    chk("t2_web4", 32'(wr_web[4]), 32'h3);
    chk("t2_data4", wr_data[4], 32'h0000A004);
    depth = 8;

    // Round-robin over four channels, two entries each.
    do_clear();
    permit_i = 1'b1; pe_array_move_i = 1'b1;
    start_tile(32'd2, 32'h1000, 4'b1111);
    wait_done("t3_done");
    chk("t3_npush3", 32'(push_total[3]), 32'd2);
    chk("t3_nwr", 32'(n_wr), 32'd8);
    for (int i = 0; i < 8; i++) begin
      logic [3:0] onehot;
      onehot = 4'b0001 << (i % 4);
      chk($sformatf("t3_pop%0d", i), 32'(wr_pop[i]), 32'(onehot));
    end
    chk("t3_ch2_addr", wr_addr[2], 32'h1800);
    chk("t3_ch2_data", wr_data[2], 32'h0000A200);
    chk("t3_ch1b_addr", wr_addr[5], 32'h1402);
    chk("t3_ch1b_data", wr_data[5], 32'hA1010000);
    chk("t3_ch1b_web", 32'(wr_web[5]), 32'hC);
    chk("t3_gap", 32'(wr_cyc[4] - wr_cyc[3]), 32'd2);

    // Grant cap: six entries in ch0, permit held high.
    do_clear();
    permit_i = 1'b1; pe_array_move_i = 1'b1;
    start_tile(32'd6, 32'h0, 4'b0001);
    wait_done("t4_done");
    chk("t4_nwr", 32'(n_wr), 32'd6);
    chk("t4_burst", 32'(wr_cyc[3] - wr_cyc[0]), 32'd3);
    chk("t4_release", 32'(wr_cyc[4] - wr_cyc[3]), 32'd2);
    chk("t4_resume", 32'(wr_cyc[5] - wr_cyc[4]), 32'd1);
    chk("t4_addr5", wr_addr[5], 32'h0000000A);

    // clear_i in DRAIN: no pop that cycle, IDLE afterwards.
    do_clear();
    pe_array_move_i = 1'b1;
    start_tile(32'd3, 32'h100, 4'b0001);
    wait_req("t5_req");
    clear_i = 1'b1; permit_i = 1'b1;
    @(negedge clk);
    chk("t5_pop_clr", 32'(fifo_pop_o), 32'd0);
    chk("t5_req_clr", {31'd0, write_req_o}, 32'd0);
    nxt();
    clear_i = 1'b0;
    chk("t5_done", {31'd0, done_o}, 32'd1);
    chk("t5_pstate", {31'd0, push_state_o}, 32'd0);
    chk("t5_nwr", 32'(n_wr), 32'd0);

    // Reset mid-DRAIN.
    do_clear();
    pe_array_move_i = 1'b1;
    start_tile(32'd3, 32'h100, 4'b0001);
    wait_req("t6_req");
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk_reset_outputs("t6");
    nxt();
    rst_n = 1'b1;

    // No channels enabled: push_cnt still counts move cycles.
    do_clear();
    permit_i = 1'b1;
    start_tile(32'd3, 32'h0, 4'b0000);
    nxt(); nxt(); nxt();
    chk("t7_hold_push", {31'd0, push_state_o}, 32'd1);
    pe_array_move_i = 1'b1;
    wait_done("t7_done");
    chk("t7_nwr", 32'(n_wr), 32'd0);
    chk("t7_npush", 32'(push_total[0]), 32'd0);

    // push_num_i == 0 goes straight to DONE.
    do_clear();
    pe_array_move_i = 1'b1;
    start_tile(32'd0, 32'h0, 4'b0001);
    chk("t8_done", {31'd0, done_o}, 32'd1);
    chk("t8_pstate", {31'd0, push_state_o}, 32'd0);
    chk("t8_push", 32'(fifo_push_o), 32'd0);

    // glb_busy_i holds off the request.
    do_clear();
    glb_busy_i = 1'b1; permit_i = 1'b1; pe_array_move_i = 1'b1;
    start_tile(32'd1, 32'h300, 4'b0001);
    nxt(); nxt(); nxt();
    chk("t9_req_busy", {31'd0, write_req_o}, 32'd0);
    chk("t9_not_done", {31'd0, done_o}, 32'd0);
    glb_busy_i = 1'b0;
    wait_done("t9_done");
    chk("t9_nwr", 32'(n_wr), 32'd1);
    chk("t9_addr", wr_addr[0], 32'h300);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
